// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the PicoRV32 two-master
//               memory arbiter (state encoding, requester indices, abort data).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter state: waiting for a request, or owning the downstream port
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Requester indices as seen on grant_id
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    // Read data returned to a requester whose transaction was aborted
    localparam logic [31:0] c_ABORT_DATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rr_pick
// Description : Combinational round-robin winner select for two requesters.
//               A lone requester always wins; on a tie the requester that did
//               not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic i_m0_valid,
    input  logic i_m1_valid,
    input  logic i_last_grant,
    output logic o_any_req,
    output logic o_winner
);

    // Pick the winner: tie goes to the requester other than the last winner
    always_comb begin
        o_any_req = i_m0_valid | i_m1_valid;
        if (i_m0_valid && i_m1_valid) begin
            o_winner = (i_last_grant == REQ_CPU) ? REQ_AUX : REQ_CPU;
        end else begin
            o_winner = i_m1_valid ? REQ_AUX : REQ_CPU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_mem_arbiter
// Description : Shares one PicoRV32 native memory port between the CPU (m0)
//               and a second bus master (m1). Round-robin grant, held until
//               mem_ready; downstream request fields are registered.
//               Optional feature macro: MEM_ARB_TIMEOUT_EN (aborts a BUSY
//               transaction after TIMEOUT_CYCLES waiting cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        grant_id,
    output logic        busy,
    output logic        timeout_err
);

    // The counter is 8 bits wide, so the limit must fit in 1..255
    generate
        if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_last_grant;
    logic        r_grant_id;
    logic        r_mem_valid;
    logic        r_mem_instr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        w_any_req;
    logic        w_winner;
    logic        w_grant;
    logic        w_done;
    logic        w_abort_now;
    logic        w_tmo_hit;
    logic        w_abort_pulse;
    logic        w_ready_evt;

    mem_arb_rr_pick u_pick (
        .i_m0_valid   (m0_valid),
        .i_m1_valid   (m1_valid),
        .i_last_grant (r_last_grant),
        .o_any_req    (w_any_req),
        .o_winner     (w_winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] r_tmo_cnt;
    logic       r_abort_pulse;

    assign w_tmo_hit     = (r_state == ARB_BUSY) && (r_tmo_cnt == c_TMO_LIMIT);
    assign w_abort_pulse = r_abort_pulse;

    // Wait counter restarts on every grant; the abort pulse trails the abort edge by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt     <= 8'd0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_abort_pulse <= w_abort_now;
            if (w_grant) begin
                r_tmo_cnt <= 8'd0;
            end else if ((r_state == ARB_BUSY) && !mem_ready && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end
`else
    assign w_tmo_hit     = 1'b0;
    assign w_abort_pulse = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and transaction events; no new grant while an abort pulse is
    // being delivered, since the aborted requester still holds valid that cycle
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_abort_now = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req && !w_abort_pulse) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort_now = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Downstream request capture on grant; fields stay frozen until the next grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid  <= 1'b0;
            r_mem_instr  <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wstrb  <= 4'h0;
            r_grant_id   <= REQ_CPU;
            r_last_grant <= REQ_AUX;
        end else if (w_grant) begin
            r_mem_valid  <= 1'b1;
            r_mem_instr  <= (w_winner == REQ_AUX) ? m1_instr : m0_instr;
            r_mem_addr   <= (w_winner == REQ_AUX) ? m1_addr  : m0_addr;
            r_mem_wdata  <= (w_winner == REQ_AUX) ? m1_wdata : m0_wdata;
            r_mem_wstrb  <= (w_winner == REQ_AUX) ? m1_wstrb : m0_wstrb;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
        end else if (w_done || w_abort_now) begin
            r_mem_valid  <= 1'b0;
        end
    end

    // Completion reaches only the granted requester; suppressed while in reset
    assign w_ready_evt = !reset && (((r_state == ARB_BUSY) && mem_ready) || w_abort_pulse);
    assign m0_ready    = w_ready_evt && (r_grant_id == REQ_CPU);
    assign m1_ready    = w_ready_evt && (r_grant_id == REQ_AUX);
    assign m0_rdata    = w_abort_pulse ? c_ABORT_DATA : mem_rdata;
    assign m1_rdata    = w_abort_pulse ? c_ABORT_DATA : mem_rdata;

    assign mem_valid   = r_mem_valid;
    assign mem_instr   = r_mem_instr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == ARB_BUSY);
    assign timeout_err = w_abort_pulse;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_mem_arbiter
// Description : Self-checking bench for picorv32_mem_arbiter: directed
//               scenarios plus randomized two-master traffic checked against
//               a transaction-level round-robin model.
//               Honours MEM_ARB_TIMEOUT_EN for the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_mem_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        grant_id, busy, timeout_err;

    int n_checks = 0;
    int n_fails  = 0;

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        settle();
        n_checks++;
        if ({mem_valid, mem_instr, busy, timeout_err, grant_id, m0_ready, m1_ready} !== 7'b0) begin
            n_fails++;
            $display("FAIL reset_ctrl: got %b want 0000000", {mem_valid, mem_instr, busy, timeout_err, grant_id, m0_ready, m1_ready});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
            n_fails++;
            $display("FAIL reset_data: addr %h wdata %h wstrb %h want all zero", mem_addr, mem_wdata, mem_wstrb);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0; m0_instr = 1'b1;
        settle();
        n_checks++;
        if (mem_valid !== 1'b0) begin
            n_fails++; $display("FAIL single_same_cycle: mem_valid %b want 0", mem_valid);
        end
        tick(); settle();
        n_checks++;
        if ({mem_valid, busy, grant_id, mem_instr, mem_addr, mem_wstrb, m0_ready} !== {1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 4'h0, 1'b0}) begin
            n_fails++;
            $display("FAIL single_issue: valid %b busy %b gid %b instr %b addr %h wstrb %h rdy %b", mem_valid, busy, grant_id, mem_instr, mem_addr, mem_wstrb, m0_ready);
        end
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        settle();
        n_checks++;
        if ({m0_ready, m1_ready, m0_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
            n_fails++;
            $display("FAIL single_ready: m0_ready %b m1_ready %b rdata %h want 1 0 00500093", m0_ready, m1_ready, m0_rdata);
        end
        // Back in IDLE with a stray mem_ready: must be ignored
        tick();
        m0_valid = 1'b0; mem_ready = 1'b1;
        settle();
        n_checks++;
        if ({mem_valid, busy, m0_ready, m1_ready} !== 4'b0) begin
            n_fails++;
            $display("FAIL single_idle: valid %b busy %b m0_ready %b m1_ready %b want 0000", mem_valid, busy, m0_ready, m1_ready);
        end
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_tie();
        logic [31:0] rd;
        logic        exp_w;
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h1000; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h2000; m1_wstrb = 4'hF; m1_wdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            exp_w = (k % 2 == 1);
            tick(); settle();
            n_checks++;
            if ({mem_valid, grant_id, mem_addr} !== {1'b1, exp_w, exp_w ? 32'h2000 : 32'h1000}) begin
                n_fails++;
                $display("FAIL tie_grant%0d: valid %b gid %b addr %h want gid %b", k, mem_valid, grant_id, mem_addr, exp_w);
            end
            tick();
            rd = $urandom; mem_ready = 1'b1; mem_rdata = rd;
            settle();
            n_checks++;
            if ({m0_ready, m1_ready} !== {!exp_w, exp_w} || (exp_w ? m1_rdata : m0_rdata) !== rd) begin
                n_fails++;
                $display("FAIL tie_ready%0d: m0_ready %b m1_ready %b rdata %h want owner %b data %h", k, m0_ready, m1_ready, exp_w ? m1_rdata : m0_rdata, exp_w, rd);
            end
            tick();
            mem_ready = 1'b0;
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold_busy();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h20; m0_wstrb = 4'h0;
        tick();
        m1_valid = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hCAFE_0000; m1_wstrb = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if ({mem_valid, grant_id, mem_addr, mem_wstrb, m1_ready} !== {1'b1, 1'b0, 32'h20, 4'h0, 1'b0}) begin
                n_fails++;
                $display("FAIL hold_frozen%0d: valid %b gid %b addr %h wstrb %h m1_ready %b", i, mem_valid, grant_id, mem_addr, mem_wstrb, m1_ready);
            end
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        settle();
        n_checks++;
        if ({m0_ready, m1_ready} !== 2'b10) begin
            n_fails++; $display("FAIL hold_m0_done: m0_ready %b m1_ready %b want 1 0", m0_ready, m1_ready);
        end
        tick();
        m0_valid = 1'b0; mem_ready = 1'b0;
        settle();
        n_checks++;
        if (mem_valid !== 1'b0) begin
            n_fails++; $display("FAIL hold_gap: mem_valid %b want 0", mem_valid);
        end
        tick(); settle();
        n_checks++;
        if ({mem_valid, grant_id, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h40, 32'hCAFE_0000, 4'b0011}) begin
            n_fails++;
            $display("FAIL hold_m1_issue: valid %b gid %b addr %h wdata %h wstrb %b", mem_valid, grant_id, mem_addr, mem_wdata, mem_wstrb);
        end
        tick();
        mem_ready = 1'b1;
        settle();
        n_checks++;
        if ({m0_ready, m1_ready} !== 2'b01) begin
            n_fails++; $display("FAIL hold_m1_done: m0_ready %b m1_ready %b want 0 1", m0_ready, m1_ready);
        end
        tick();
        m1_valid = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h80; m0_wstrb = 4'h0;
`ifdef MEM_ARB_TIMEOUT_EN
        logic [31:0] rd;
        tick();
        // BUSY lasts TMO+1 cycles before the abort edge
        for (int i = 0; i <= int'(TMO); i++) begin
            settle();
            n_checks++;
            if ({mem_valid, timeout_err, m0_ready} !== 3'b100) begin
                n_fails++; $display("FAIL tmo_wait%0d: valid %b err %b m0_ready %b want 1 0 0", i, mem_valid, timeout_err, m0_ready);
            end
            tick();
        end
        settle();
        n_checks++;
        if ({timeout_err, m0_ready, m1_ready, mem_valid, m0_rdata} !== {4'b1100, 32'hDEADBEEF}) begin
            n_fails++;
            $display("FAIL tmo_abort: err %b m0_ready %b m1_ready %b valid %b rdata %h", timeout_err, m0_ready, m1_ready, mem_valid, m0_rdata);
        end
        tick();
        m0_valid = 1'b0;
        settle();
        n_checks++;
        if ({timeout_err, mem_valid, busy} !== 3'b000) begin
            n_fails++; $display("FAIL tmo_after: err %b valid %b busy %b want 000", timeout_err, mem_valid, busy);
        end
        // mem_ready on the limit cycle wins over the abort
        tick();
        m0_valid = 1'b1;
        tick();
        for (int i = 0; i < int'(TMO); i++) tick();
        rd = $urandom; mem_ready = 1'b1; mem_rdata = rd;
        settle();
        n_checks++;
        if ({m0_ready, timeout_err, m0_rdata} !== {2'b10, rd}) begin
            n_fails++; $display("FAIL tmo_race: m0_ready %b err %b rdata %h want 1 0 %h", m0_ready, timeout_err, m0_rdata, rd);
        end
        tick();
        m0_valid = 1'b0; mem_ready = 1'b0;
        settle();
        n_checks++;
        if ({timeout_err, mem_valid} !== 2'b00) begin
            n_fails++; $display("FAIL tmo_race_after: err %b valid %b want 00", timeout_err, mem_valid);
        end
`else
        tick();
        for (int i = 0; i < 100; i++) begin
            settle();
            n_checks++;
            if ({mem_valid, busy, m0_ready, timeout_err} !== 4'b1100) begin
                n_fails++; $display("FAIL notmo_hold%0d: valid %b busy %b m0_ready %b err %b", i, mem_valid, busy, m0_ready, timeout_err);
            end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        n_checks++;
        if (m0_ready !== 1'b1) begin
            n_fails++; $display("FAIL notmo_done: m0_ready %b want 1", m0_ready);
        end
        tick();
        m0_valid = 1'b0; mem_ready = 1'b0;
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        tick(); settle();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++; $display("FAIL rstmid_pre: busy %b want 1", busy);
        end
        tick();
        reset = 1'b1; m1_valid = 1'b1; m1_addr = 32'h200;
        settle();
        n_checks++;
        if ({m0_ready, m1_ready} !== 2'b00) begin
            n_fails++; $display("FAIL rstmid_noready: m0_ready %b m1_ready %b want 00", m0_ready, m1_ready);
        end
        tick(); settle();
        n_checks++;
        if ({mem_valid, busy, grant_id, timeout_err, mem_addr, m0_ready} !== {4'b0000, 32'h0, 1'b0}) begin
            n_fails++;
            $display("FAIL rstmid_state: valid %b busy %b gid %b err %b addr %h m0_ready %b", mem_valid, busy, grant_id, timeout_err, mem_addr, m0_ready);
        end
        reset = 1'b0;
        tick(); settle();
        n_checks++;
        if ({mem_valid, grant_id, mem_addr} !== {2'b10, 32'h100}) begin
            n_fails++; $display("FAIL rstmid_tie: valid %b gid %b addr %h want 1 0 00000100", mem_valid, grant_id, mem_addr);
        end
        do_reset();
    endtask

    // Random traffic; the model tracks ownership at transaction level
    task automatic test_random(input int n);
        logic [31:0] t_addr [2];
        logic [31:0] t_wdata [2];
        logic [3:0]  t_wstrb [2];
        logic        t_instr [2];
        bit          pend [2];
        bit          mbusy;
        int          owner, last, lat;
        logic [31:0] rd;
        logic [69:0] got, exp;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            t_addr[m] = 32'h0; t_wdata[m] = 32'h0; t_wstrb[m] = 4'h0; t_instr[m] = 1'b0; pend[m] = 1'b0;
        end
        mbusy = 1'b0; owner = 0; last = 1; lat = 0;
        for (int c = 0; c < n; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
                    pend[m] = 1'b1;
                    t_addr[m] = $urandom; t_wdata[m] = $urandom;
                    t_wstrb[m] = 4'($urandom_range(0, 15)); t_instr[m] = 1'($urandom_range(0, 1));
                end
            end
            m0_valid = pend[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0]; m0_wstrb = t_wstrb[0]; m0_instr = t_instr[0];
            m1_valid = pend[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1]; m1_wstrb = t_wstrb[1]; m1_instr = t_instr[1];
            rd = $urandom; mem_rdata = rd;
            mem_ready = mbusy ? (lat == 0) : 1'($urandom_range(0, 1));
            settle();
            n_checks++;
            if ({busy, mem_valid, m0_ready, m1_ready, timeout_err} !==
                {mbusy, mbusy, mbusy && lat == 0 && owner == 0, mbusy && lat == 0 && owner == 1, 1'b0}) begin
                n_fails++;
                $display("FAIL rand_ctrl c%0d: busy %b valid %b m0r %b m1r %b err %b model busy %b owner %0d lat %0d",
                         c, busy, mem_valid, m0_ready, m1_ready, timeout_err, mbusy, owner, lat);
            end
            if (mbusy) begin
                got = {mem_addr, mem_wdata, mem_wstrb, mem_instr, grant_id};
                exp = {t_addr[owner], t_wdata[owner], t_wstrb[owner], t_instr[owner], 1'(owner)};
                n_checks++;
                if (got !== exp) begin
                    n_fails++; $display("FAIL rand_req c%0d: got %h want %h", c, got, exp);
                end
                if (lat == 0) begin
                    n_checks++;
                    if ((owner == 0 ? m0_rdata : m1_rdata) !== rd) begin
                        n_fails++; $display("FAIL rand_rdata c%0d: got %h want %h", c, owner == 0 ? m0_rdata : m1_rdata, rd);
                    end
                end
            end
            if (mbusy) begin
                if (lat == 0) begin
                    mbusy = 1'b0;
                    pend[owner] = 1'b0;
                end else begin
                    lat--;
                end
            end else if (pend[0] || pend[1]) begin
                owner = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
                last  = owner;
                mbusy = 1'b1;
                lat   = $urandom_range(0, 3);
            end
            tick();
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_hold_busy();
        test_timeout();
        test_reset_mid();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-master arbiter that shares one PicoRV32-style native memory port (valid/ready, addr/wdata/wstrb/rdata) between the CPU (requester 0) and a second bus master such as a DMA or program loader (requester 1). It sits between the `picorv32` core's memory pins and the single memory model or SRAM. Arbitration is round-robin, and a grant is held until the downstream `mem_ready` arrives. Downstream request signals are registered, so they stay stable for the whole transaction.

## Interface
- `TIMEOUT_CYCLES`, default 255: downstream wait limit in BUSY; used only with the timeout feature; legal range 1..255.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_valid`, `m1_valid` in 1: request from the CPU / second master; held high until the matching ready.
- `m0_instr`, `m1_instr` in 1: instruction-fetch flag, forwarded downstream.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_wstrb`, `m1_wstrb` in 4: byte strobes; `0000` means read.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse to the granted requester.
- `m0_rdata`, `m1_rdata` out 32: read data; valid only while the matching ready is high.
- `mem_valid` out 1: downstream request.
- `mem_instr` out 1: downstream instruction flag.
- `mem_addr` out 32: downstream address.
- `mem_wdata` out 32: downstream write data.
- `mem_wstrb` out 4: downstream strobes.
- `mem_ready` in 1: downstream completion.
- `mem_rdata` in 32: downstream read data.
- `grant_id` out 1: index of the current or last winner.
- `busy` out 1: high in BUSY.
- `timeout_err` out 1: one-cycle pulse when a transaction is aborted.

## Operation
- There are two states: IDLE and BUSY.
- **IDLE**
  - With no valid request, stay in IDLE.
  - With exactly one valid request, grant it.
  - With both valid, grant the requester other than `last_grant` (round-robin).
  - On a grant: register the winner's addr/wdata/wstrb/instr into the `mem_*` outputs, set `mem_valid`=1, `grant_id`=winner and `last_grant`=winner, then go to BUSY.
- **BUSY**
  - Downstream outputs are frozen.
  - `mX_ready = mem_ready && grant_id==X`, combinational; the non-granted ready stays 0.
  - `m0_rdata` and `m1_rdata` both carry `mem_rdata` unconditionally.
  - When `mem_ready`=1: clear `mem_valid` at the edge and return to IDLE.
- `mem_ready` is ignored in IDLE.
- A requester that drops valid before its ready (protocol violation) does not cancel the downstream transaction.
- The outcome of a downstream write is not checked by the arbiter; strobes pass through bit-exact.

## Timing
- **Reset values:**
  - `mem_valid`, `mem_instr`, `busy`, `timeout_err`, `grant_id` = 0.
  - `mem_addr`, `mem_wdata` = 32'h0; `mem_wstrb` = 4'h0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - State = IDLE.
- Reset during BUSY: `mem_valid` drops at that edge and no upstream ready is issued. The aborted requester re-arbitrates after reset is released.
- **Latency:**
  - Valid seen in IDLE at cycle N gives `mem_valid`=1 from cycle N+1.
  - Upstream ready is issued in the same cycle as `mem_ready`.
  - Back in IDLE the following cycle.
- Minimum spacing between downstream transactions is one IDLE cycle. With a 1-cycle-latency memory this gives 3 cycles per access.
- Under continuous contention, grants alternate 0,1,0,1.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without `mem_ready`.
  - When the counter equals `TIMEOUT_CYCLES`, that edge performs the abort:
    - `mem_valid` is cleared;
    - the granted requester gets a ready pulse in the next cycle, with `mX_rdata` = 32'hDEADBEEF;
    - `timeout_err` pulses for that cycle;
    - the state then returns to IDLE.
  - `mem_ready` arriving in the same cycle as the limit wins, and no error is flagged.
- **Undefined:** no counter; BUSY waits indefinitely; `timeout_err` is tied 0.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_BUSY`);
  - requester index constants `REQ_CPU`=0 and `REQ_AUX`=1;
  - the abort data constant 32'hDEADBEEF.
- One natural sub-module, `mem_arb_rr_pick`: combinational winner select from (`m0_valid`, `m1_valid`, `last_grant`), outputting `any_req` and `winner`.
- Everything else lives in the top module.

## Test plan
- **Single read:** m0 reads addr 32'h10; memory returns 32'h00500093 with 1-cycle latency. Expect `mem_valid` 1 cycle after request, `m0_ready` plus that data 2 cycles after request, and `m1_ready` stays 0.
- **Tie:** both valid in the same IDLE cycle, held across two transactions. Expect grants 0 then 1 (`grant_id` 0→1) and each ready delivered only to its owner.
- **Hold during BUSY:** m1 writes 32'hCAFE_0000 with strobe 4'b0011 while m0 is BUSY. Expect it to wait, then appear downstream with strobe 4'b0011 unmodified after m0's completion plus one IDLE cycle.
- **Timeout:** `TIMEOUT_CYCLES`=4 with `mem_ready` never asserted. Expect `timeout_err` pulse, m0 ready with 32'hDEADBEEF, and `mem_valid` low afterwards; with the macro off, BUSY holds for 100 cycles.
- **Reset mid-transaction:** assert `reset` during BUSY. Expect all outputs at reset values the next cycle and no ready pulse; the first post-reset tie goes to requester 0.
